oddr_tx_sequencer: RTL and testbench
====================================

Name: oddr_tx_sequencer

Overview:
- Serializes parallel words into a DDR output register with async clear/preset and clock enable: two bits per clock, d0 on the rising edge and d1 on the falling edge.
- Accepts words through a valid/ready handshake from the fabric.
- Drives d0, d1, ce, clr and pre of the DDR output flop/buffer pair.
- Sits between transmit logic and the pad-level DDR primitive. It owns idle-level parking, optional inter-word gaps and abort flushing.

Parameters:
- WIDTH, 8, word width in bits; must be even and ≥ 2.
- GAP_CYCLES, 0, idle-level cycles inserted after each word (0..15).
- IDLE_LEVEL, 1'b0, line level driven when no word is being sent.

Ports:
- C  input  1  clock; also drives C0 of the DDR flop (C1 = ~C externally).
- R  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  word to send; sent LSB first.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- abort  input  1  synchronous abort: discard the current word and park the line.
- d0  output  1  bit for the rising-edge slot (to D0).
- d1  output  1  bit for the falling-edge slot (to D1).
- ce  output  1  DDR flop clock enable.
- clr  output  1  DDR flop clear request.
- pre  output  1  DDR flop preset request.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- One clock C. Reset R is synchronous and active-high. All outputs except in_ready are registered.
- Reset values:
  - state=IDLE, ce=0, d0=d1=IDLE_LEVEL, busy=0, in_ready=0.
  - clr=(IDLE_LEVEL==0), pre=(IDLE_LEVEL==1).
- First cycle after R falls: ce=1, clr=pre=0.
- FSM states IDLE, SHIFT, GAP. Pair counter cnt is ceil(log2(WIDTH/2)) bits. Gap counter gcnt is 4 bits.
- IDLE:
  - in_ready=1. Outputs: ce=1, d0=d1=IDLE_LEVEL.
  - Transfer when in_valid&&in_ready at edge t. Then:
    - d0<=in_data[0], d1<=in_data[1];
    - shreg<=in_data>>2;
    - cnt<=WIDTH/2-1;
    - state<=SHIFT.
  - Pair k is therefore visible on d0/d1 during cycle t+1+k, for k=0..WIDTH/2-1.
- SHIFT:
  - Each edge while cnt!=0: d0<=shreg[0], d1<=shreg[1], shreg>>=2, cnt--.
  - in_ready=1 only in the last pair cycle (cnt==0) and only when GAP_CYCLES==0.
  - A transfer in that cycle loads the next word with no bubble: continuous streaming at 2 bits per clock.
  - cnt==0 with no transfer: go to GAP if GAP_CYCLES>0, else to IDLE. In both cases d0=d1<=IDLE_LEVEL.
- GAP:
  - d0=d1=IDLE_LEVEL and in_ready=0 for exactly GAP_CYCLES cycles (gcnt counts down), then IDLE.
- ce stays 1 in every state after reset.
- abort (any state, lower priority than R):
  - Next edge: state<=IDLE, shreg and cnt cleared, d0=d1<=IDLE_LEVEL, ce<=0.
  - clr or pre (per IDLE_LEVEL) pulses high for exactly one cycle.
  - in_ready=0 during the abort cycle, so no word is accepted.
- Simultaneous abort and in_valid: abort wins and the word is not consumed.
- abort held for N cycles gives a clr/pre pulse N cycles long. Normal operation resumes the cycle after abort falls.
- clr and pre are never high simultaneously.
- busy=1 exactly in SHIFT and GAP.
- in_data is sampled only on a transfer edge. It may change at any other time.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2), and a function computing counter width from WIDTH.
- Natural sub-module: oddr_tx_shifter. It holds the shift register, pair counter and d0/d1 registers, exposing load and last.
- The FSM, gap counter and abort/clr/pre logic stay in oddr_tx_sequencer.

Test Plan:
- Reset: R high 3 cycles, IDLE_LEVEL=0 -> clr=1, ce=0, d0=d1=0 throughout reset; the cycle after R falls, clr=0, ce=1, in_ready=1.
- Single word 8'hB4, GAP_CYCLES=0 -> d0/d1 pairs over 4 cycles are (0,0),(1,0),(1,1),(0,1); then d0=d1=0 and busy=0.
- Back-to-back 8'hFF then 8'h00 with in_valid held -> 4 cycles of d0=d1=1 immediately followed by 4 cycles of 0; in_ready high only in cycles 4 and 8.
- GAP_CYCLES=3, two words queued -> exactly 3 idle cycles between words; in_ready=0 during the gap.
- abort in pair cycle 2 of 8'hAA, IDLE_LEVEL=1 -> next cycle pre=1 for one cycle, ce=0, d0=d1=1, state IDLE; a word presented in the abort cycle is not consumed.
- WIDTH=2 -> one pair per word; continuous streaming at one word per clock with in_ready constantly high.

Source files
------------

// File: rtl/oddr_tx_sequencer_pkg.sv
// rtl/oddr_tx_sequencer_pkg.sv - shared state encoding and sizing helper for the DDR transmit sequencer
package oddr_tx_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Pair counter width; a single-pair word still gets a 1-bit counter.
    function automatic int cnt_width(input int width);
        int n;
        n = 1;
        while ((1 << n) < (width / 2)) n++;
        return n;
    endfunction

endpackage

// File: rtl/oddr_tx_shifter.sv
// rtl/oddr_tx_shifter.sv - two-bit-per-clock shift register feeding the DDR d0/d1 pins
module oddr_tx_shifter
    import oddr_tx_sequencer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             C,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             d0,
    output logic             d1,
    output logic             last
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d0_q, d0_d;
    logic             d1_q, d1_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        d0_d    = IDLE_LEVEL;
        d1_d    = IDLE_LEVEL;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (load) begin
            d0_d    = data[0];
            d1_d    = data[1];
            shreg_d = data >> 2;
            cnt_d   = CW'(WIDTH / 2 - 1);
        end else if (cnt_q != '0) begin
            d0_d    = shreg_q[0];
            d1_d    = shreg_q[1];
            shreg_d = shreg_q >> 2;
            cnt_d   = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge C) begin
        shreg_q <= shreg_d;
        cnt_q   <= cnt_d;
        d0_q    <= d0_d;
        d1_q    <= d1_d;
    end

    assign d0   = d0_q;
    assign d1   = d1_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/oddr_tx_sequencer.sv
// rtl/oddr_tx_sequencer.sv - word handshake, gap insertion and abort parking in front of a DDR output flop
module oddr_tx_sequencer
    import oddr_tx_sequencer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             d0,
    output logic             d1,
    output logic             ce,
    output logic             clr,
    output logic             pre,
    output logic             busy
);

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_e     state_q, state_d;
    logic [3:0] gcnt_q, gcnt_d;
    logic       ce_q, clr_q, pre_q;
    logic       last;
    logic       xfer;

    oddr_tx_shifter #(
        .WIDTH      (WIDTH),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_shifter (
        .C     (C),
        .clear (R | abort),
        .load  (xfer),
        .data  (in_data),
        .d0    (d0),
        .d1    (d1),
        .last  (last)
    );

    always_comb begin
        state_d  = state_q;
        gcnt_d   = gcnt_q;
        in_ready = 1'b0;
        if (!R && !abort) begin
            in_ready = (state_q == ST_IDLE) ||
                       (state_q == ST_SHIFT && last && GAP_CYCLES == 0);
        end
        xfer = in_valid && in_ready;

        case (state_q)
            ST_IDLE: begin
                if (xfer) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last) begin
                    if (xfer) begin
                        state_d = ST_SHIFT;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        gcnt_d  = GAP_LAST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gcnt_q == 4'd0) state_d = ST_IDLE;
                else                gcnt_d  = gcnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            gcnt_d  = 4'd0;
        end
    end

    // The clear/preset request parks the pad at the idle level while reset or abort is active.
    always_ff @(posedge C) begin
        if (R) begin
            state_q <= ST_IDLE;
            gcnt_q  <= 4'd0;
            ce_q    <= 1'b0;
            clr_q   <= (IDLE_LEVEL == 1'b0);
            pre_q   <= (IDLE_LEVEL == 1'b1);
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            ce_q    <= !abort;
            clr_q   <= abort && (IDLE_LEVEL == 1'b0);
            pre_q   <= abort && (IDLE_LEVEL == 1'b1);
        end
    end

    assign ce   = ce_q;
    assign clr  = clr_q;
    assign pre  = pre_q;
    assign busy = (state_q == ST_SHIFT) || (state_q == ST_GAP);

endmodule

// File: tb/tb_oddr_tx_sequencer.sv
// tb/tb_oddr_tx_sequencer.sv - scoreboard bench over three parameterisations of the DDR transmit sequencer
module tb_oddr_tx_sequencer;

    logic C = 1'b0;
    always #5 C = ~C;

    int errors = 0;
    int checks = 0;
    logic [2:0] done = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int   W = (g == 2) ? 2 : 8;
        localparam int   G = (g == 1) ? 3 : 0;
        localparam logic L = (g == 1) ? 1'b1 : 1'b0;

        logic         R        = 1'b1;
        logic         in_valid = 1'b0;
        logic         abort    = 1'b0;
        logic [W-1:0] in_data  = '0;
        logic         in_ready, d0, d1, ce, clr, pre, busy;
        logic         r_q  = 1'bx;
        logic         ab_q = 1'b0;
        logic [1:0]   q[$];

        oddr_tx_sequencer #(
            .WIDTH      (W),
            .GAP_CYCLES (G),
            .IDLE_LEVEL (L)
        ) dut (
            .C        (C),
            .R        (R),
            .in_data  (in_data),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .abort    (abort),
            .d0       (d0),
            .d1       (d1),
            .ce       (ce),
            .clr      (clr),
            .pre      (pre),
            .busy     (busy)
        );

        always @(posedge C) begin
            r_q  <= R;
            ab_q <= abort && !R;
        end

        task automatic push_word(input logic [W-1:0] dat);
            for (int k = 0; k < W / 2; k++) q.push_back({dat[2*k+1], dat[2*k]});
            for (int j = 0; j < G; j++) q.push_back({L, L});
        endtask

        task automatic step(input logic v, input logic [W-1:0] dat, input logic ab,
                            input logic rst, output logic acc);
            logic rdy;
            R        = rst;
            in_valid = v;
            in_data  = dat;
            abort    = ab;
            @(negedge C);
            rdy = in_ready;
            @(posedge C);
            acc = v && rdy && !ab && !rst;
            if (ab && !rst) q.delete();
            else if (acc) push_word(dat);
            #1;
        endtask

        task automatic idle(input int n, input logic rst);
            logic acc;
            for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rst, acc);
        endtask

        task automatic send(input logic [W-1:0] dat);
            logic acc;
            int   n;
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 20) begin
                step(1'b1, dat, 1'b0, 1'b0, acc);
                n++;
            end
            chk($sformatf("i%0d_accept_%0h", g, dat), acc, 1'b1);
        endtask

        always @(negedge C) begin
            if (!$isunknown(r_q)) begin
                logic park, exp_busy, exp_rdy;
                logic [1:0] e;
                park     = r_q || ab_q;
                exp_busy = (q.size() != 0);
                exp_rdy  = !R && !abort && (q.size() == 0 || (G == 0 && q.size() == 1));
                chk($sformatf("i%0d_ce", g), ce, !park);
                chk($sformatf("i%0d_clr", g), clr, park && !L);
                chk($sformatf("i%0d_pre", g), pre, park && L);
                chk($sformatf("i%0d_busy", g), busy, exp_busy);
                chk($sformatf("i%0d_in_ready", g), in_ready, exp_rdy);
                if (exp_busy) begin
                    e = q.pop_front();
                    chk($sformatf("i%0d_pair", g), {d1, d0}, e);
                end else begin
                    chk($sformatf("i%0d_idle_line", g), {d1, d0}, {L, L});
                end
            end
        end

        if (g == 0) begin : stim
            initial begin
                idle(3, 1'b1);
                idle(2, 1'b0);
                send(8'hB4);
                idle(6, 1'b0);
                send(8'hFF);
                send(8'h00);
                send(8'h5A);
                idle(6, 1'b0);
                done[0] = 1'b1;
            end
        end else if (g == 1) begin : stim
            initial begin
                logic acc;
                idle(3, 1'b1);
                idle(2, 1'b0);
                send(8'h96);
                send(8'h0F);
                idle(10, 1'b0);
                send(8'hAA);
                step(1'b0, '0, 1'b0, 1'b0, acc);
                step(1'b0, '0, 1'b0, 1'b0, acc);
                step(1'b1, 8'h33, 1'b1, 1'b0, acc);
                chk("i1_abort_word_taken", acc, 1'b0);
                idle(3, 1'b0);
                send(8'hC3);
                step(1'b0, '0, 1'b0, 1'b0, acc);
                step(1'b0, '0, 1'b1, 1'b0, acc);
                step(1'b0, '0, 1'b1, 1'b0, acc);
                idle(4, 1'b0);
                send(8'h81);
                idle(10, 1'b0);
                done[1] = 1'b1;
            end
        end else begin : stim
            initial begin
                idle(3, 1'b1);
                idle(1, 1'b0);
                send(2'b01);
                send(2'b10);
                send(2'b11);
                send(2'b00);
                send(2'b10);
                idle(3, 1'b0);
                done[2] = 1'b1;
            end
        end
    end

    initial begin
        for (int i = 0; i < 5000 && !(&done); i++) @(posedge C);
        if (!(&done)) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: done=%b expected 111", done);
        end
        @(negedge C);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
